ddc_burst_arb: RTL
==================

DDC_BURST_ARB -- requirements
Module: ddc_burst_arb

Interface
REQ-001 The block SHALL have parameter N_CH, default 16, giving beats per channel burst (legal 2..256).
REQ-002 The block SHALL have parameter TIMEOUT, default 256, giving the maximum number of consecutive stall cycles tolerated inside a burst (legal 1..1024).
REQ-003 s_axis_aclk  in  1  sole clock; all logic on the rising edge.
REQ-004 s_axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 s0_axis_tdata  in  96  source 0 data; s0_axis_tvalid  in  1; s0_axis_tready  out  1.
REQ-006 s1_axis_tdata  in  96  source 1 data; s1_axis_tvalid  in  1; s1_axis_tready  out  1.
REQ-007 m_axis_tdata  out  96  merged data; m_axis_tvalid  out  1; m_axis_tready  in  1.
REQ-008 m_axis_tlast  out  1  high on the final (N_CH-th) beat of a burst.
REQ-009 m_axis_tid  out  1  index of the source owning the current beat.
REQ-010 err_timeout  out  1  one-cycle pulse when a burst is aborted by timeout.

Function
REQ-011 The block SHALL implement the states IDLE and BURST.
REQ-012 IDLE: both s*_tready SHALL be 0 and m_axis_tvalid SHALL be 0.
REQ-013 IDLE with any s*_tvalid=1: the block SHALL register a grant and enter BURST on the next edge.
- Only one valid: that source wins.
- Both valid: the source other than last_grant wins (round-robin).
REQ-014 BURST: m_axis_tdata/tvalid SHALL mux combinationally from the granted source; the granted s*_tready SHALL equal m_axis_tready; the non-granted tready SHALL be 0.
REQ-015 m_axis_tid SHALL equal the registered grant while in BURST and hold its last value in IDLE.
REQ-016 A beat counter, width clog2(N_CH), SHALL increment on each master handshake (tvalid&tready) and clear on entry to BURST.
REQ-017 m_axis_tlast SHALL be 1 only in BURST with beat counter = N_CH-1, combinational.
REQ-018 Handshake on beat N_CH-1: the block SHALL return to IDLE, set last_grant to the granted source, and clear the counter.
REQ-019 Minimum gap between bursts SHALL be exactly one IDLE cycle; throughput of N_CH beats per N_CH+1 cycles with no stalls.
REQ-020 A stall counter SHALL increment each BURST cycle in which the granted tvalid=0, and clear on any cycle with granted tvalid=1 or on entering BURST.
- Cycles with tvalid=1 and m_axis_tready=0 (backpressure) SHALL NOT count as stall.
REQ-021 Stall counter reaching TIMEOUT: the next edge SHALL
- return the block to IDLE;
- pulse err_timeout for exactly one cycle;
- set last_grant to the aborted source.
- No tlast SHALL be emitted for the truncated burst.
REQ-022 A stall cycle coincident with counter = TIMEOUT-1 SHALL trigger abort; a valid arriving in that same cycle SHALL clear the counter and prevent abort.
REQ-023 The non-granted source's tvalid SHALL have no effect in BURST; its data SHALL be held by it, never dropped by the block.
REQ-024 The block SHALL NOT alter tdata; m_axis_tdata SHALL equal the granted source's tdata bit-for-bit.

Reset
REQ-025 Assertion of s_axis_aresetn=0 SHALL immediately force:
- state=IDLE, beat and stall counters=0, last_grant=1 (source 0 wins first tie);
- all tready=0, m_axis_tvalid=0, tlast=0, tid=0, err_timeout=0.
REQ-026 Reset asserted mid-burst SHALL discard the burst; after release the first grant SHALL occur no earlier than the first edge with reset high.

Verification
REQ-027 Both sources valid continuously, N_CH=16, tready=1 -> bursts alternate s0,s1,s0...; 16 beats each; tlast on beat 16; one idle cycle between bursts.
REQ-028 s1 only valid -> s1 granted back-to-back every 17 cycles; tid=1; s0_tready stays 0.
REQ-029 m_axis_tready toggled 0/1 during s0 burst for 1000 cycles, TIMEOUT=8 -> no abort, err_timeout never 1, exactly 16 handshakes then tlast.
REQ-030 s0 drops tvalid after beat 5 for 8 cycles, TIMEOUT=8 -> err_timeout pulses once; return to IDLE; s1 granted next if valid; no tlast seen.
REQ-031 s0 stalls 7 cycles, then resumes, TIMEOUT=8 -> no abort; burst completes with tlast at beat 16.
REQ-032 Reset pulsed at beat 10 of an s1 burst -> outputs at reset values that cycle; after release with both valid, s0 granted first.

Source files
------------

// File: rtl/ddc_burst_arb.sv
// Two-source round-robin burst arbiter onto one AXI-Stream master.
// Each grant owns the master for N_CH beats or until a stall timeout.
module ddc_burst_arb #(
  parameter int N_CH    = 16,
  parameter int TIMEOUT = 256
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic [95:0] s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic [95:0] s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  output logic [95:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tid,
  output logic        err_timeout
);

  localparam int BW = $clog2(N_CH);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_CH - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic [BW-1:0] r_beat;
  logic [SW-1:0] r_stall;
  logic          r_err;

  logic w_burst;
  logic w_gv;
  logic w_hs;
  logic w_last;
  logic w_pick;

  assign w_burst = (r_state == BURST);
  assign w_gv    = r_grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_last  = w_burst && (r_beat == LAST_BEAT);
  assign w_hs    = w_burst && w_gv && m_axis_tready;

  // on a tie the source that did not own the previous burst wins
  assign w_pick  = (s0_axis_tvalid && s1_axis_tvalid) ?
                   ~r_last_grant : s1_axis_tvalid;

  assign m_axis_tdata   = r_grant ? s1_axis_tdata : s0_axis_tdata;
  assign m_axis_tvalid  = w_burst && w_gv;
  assign m_axis_tlast   = w_last;
  assign m_axis_tid     = r_grant;
  assign s0_axis_tready = w_burst && !r_grant && m_axis_tready;
  assign s1_axis_tready = w_burst && r_grant && m_axis_tready;
  assign err_timeout    = r_err;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat       <= '0;
      r_stall      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            r_state <= BURST;
            r_grant <= w_pick;
            r_beat  <= '0;
            r_stall <= '0;
          end
        end
        BURST: begin
          if (w_hs) begin
            if (w_last) begin
              r_state      <= IDLE;
              r_last_grant <= r_grant;
              r_beat       <= '0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
          // backpressure with valid high is not a stall
          if (w_gv) begin
            r_stall <= '0;
          end else if (r_stall == STALL_MAX) begin
            r_state      <= IDLE;
            r_err        <= 1'b1;
            r_last_grant <= r_grant;
            r_beat       <= '0;
            r_stall      <= '0;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
